mem_bus_responder: RTL and testbench

- Memory-side partner of the multicycle control FSM. Accepts one-cycle MemRead/MemWrite strobes with store-size and load-case codes, then runs a word-aligned req/ack transaction on the memory bus with variable wait states.
- Handles byte-lane steering on writes and sign/zero extension on reads.
- Returns a one-cycle done pulse so the control FSM can hold its state until the access completes.
- Flags misaligned, conflicting and timed-out accesses.

---
 rtl/mem_bus_responder_if.sv | 41 ++++
 rtl/mem_bus_responder.sv | 146 ++++++++++++++
 tb/tb_mem_bus_responder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_responder_if.sv
// mem_bus_responder_if: CPU-side strobes and memory-bus handshake for the
// memory responder.
//   CPU side : iMemRead/iMemWrite strobes, iAddr, iWData, iStore, iLoadCase in;
//              oRData, oReady, oBusy, oFault out.
//   Bus side : oBusReq, oBusWE, oBusAddr, oBusWData, oBusBE out;
//              iBusAck, iBusRData in.
// The responder uses the slave modport. The master modport is for whatever
// drives the CPU side and models the memory.
interface mem_bus_responder_if;
  logic        iMemRead;
  logic        iMemWrite;
  logic [31:0] iAddr;
  logic [31:0] iWData;
  logic [2:0]  iStore;
  logic [2:0]  iLoadCase;
  logic [31:0] oRData;
  logic        oReady;
  logic        oBusy;
  logic        oFault;
  logic        oBusReq;
  logic        oBusWE;
  logic [31:0] oBusAddr;
  logic [31:0] oBusWData;
  logic [3:0]  oBusBE;
  logic        iBusAck;
  logic [31:0] iBusRData;

  modport slave (
    input  iMemRead, iMemWrite, iAddr, iWData, iStore, iLoadCase,
    input  iBusAck, iBusRData,
    output oRData, oReady, oBusy, oFault,
    output oBusReq, oBusWE, oBusAddr, oBusWData, oBusBE
  );

  modport master (
    output iMemRead, iMemWrite, iAddr, iWData, iStore, iLoadCase,
    output iBusAck, iBusRData,
    input  oRData, oReady, oBusy, oFault,
    input  oBusReq, oBusWE, oBusAddr, oBusWData, oBusBE
  );
endinterface

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: this block takes one-cycle MemRead/MemWrite strobes from
// the multicycle control FSM. For each legal strobe it runs one word-aligned
// req/ack transaction on the memory bus. On writes it steers the bytes to the
// correct lanes. On reads it applies sign or zero extension. It returns a
// one-cycle oReady pulse when the access completes. It returns a one-cycle
// oFault pulse when the request is illegal, misaligned, or times out.
//   iCLK, iRST_N : clock and asynchronous active-low reset
//   bus (slave)  : CPU-side strobes and results, plus memory-bus handshake
//   TIMEOUT      : number of REQ cycles without an ack before the access is aborted (1..255)
module mem_bus_responder #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  mem_bus_responder_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic [2:0]  lc_q;
  logic [1:0]  off_q;
  logic [31:0] rdata_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  // Decode the request. This decode is only acted on while the FSM is in IDLE.
  logic rd_req, wr_req, both_req, st_bad, lc_bad, wr_mis, rd_mis, bad, go;

  always_comb begin
    rd_req   = bus.iMemRead & ~bus.iMemWrite;
    wr_req   = bus.iMemWrite & ~bus.iMemRead;
    both_req = bus.iMemRead & bus.iMemWrite;
    st_bad   = bus.iStore > 3'd2;
    lc_bad   = bus.iLoadCase > 3'd4;
    wr_mis   = ((bus.iStore == 3'd0) && (bus.iAddr[1:0] != 2'b00)) ||
               ((bus.iStore == 3'd1) && bus.iAddr[0]);
    rd_mis   = ((bus.iLoadCase == 3'd0) && (bus.iAddr[1:0] != 2'b00)) ||
               (((bus.iLoadCase == 3'd1) || (bus.iLoadCase == 3'd2)) && bus.iAddr[0]);
    bad      = both_req | (wr_req & (st_bad | wr_mis)) | (rd_req & (lc_bad | rd_mis));
    go       = (rd_req | wr_req) & ~bad;
  end

  // Compute the write lanes at accept time, so the bus only ever sees registers.
  // A read asks for the whole word. The extraction happens on the return path.
  logic [3:0]  be_n;
  logic [31:0] wd_n;

  always_comb begin
    be_n = 4'hF;
    wd_n = bus.iWData;
    if (wr_req) begin
      case (bus.iStore)
        3'd1: begin
          be_n = bus.iAddr[1] ? 4'b1100 : 4'b0011;
          wd_n = {2{bus.iWData[15:0]}};
        end
        3'd2: begin
          be_n = 4'b0001 << bus.iAddr[1:0];
          wd_n = {4{bus.iWData[7:0]}};
        end
        default: ;
      endcase
    end
  end

  // Read extraction. It uses the offset latched at accept time, not the live iAddr.
  logic [15:0] half;
  logic [7:0]  byte_sel;
  logic [31:0] ext;

  always_comb begin
    half     = off_q[1] ? bus.iBusRData[31:16] : bus.iBusRData[15:0];
    byte_sel = bus.iBusRData[{off_q, 3'b000} +: 8];
    case (lc_q)
      3'd1:    ext = {{16{half[15]}}, half};
      3'd2:    ext = {16'h0000, half};
      3'd3:    ext = {{24{byte_sel[7]}}, byte_sel};
      3'd4:    ext = {24'h000000, byte_sel};
      default: ext = bus.iBusRData;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state   <= S_IDLE;
      cnt     <= 8'd0;
      lc_q    <= 3'd0;
      off_q   <= 2'd0;
      rdata_q <= 32'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            state   <= S_REQ;
            cnt     <= 8'd0;
            lc_q    <= bus.iLoadCase;
            off_q   <= bus.iAddr[1:0];
            we_q    <= wr_req;
            addr_q  <= {bus.iAddr[31:2], 2'b00};
            wdata_q <= wd_n;
            be_q    <= be_n;
          end else if (bad) begin
            state <= S_FAULT;
          end
        end
        S_REQ: begin
          if (bus.iBusAck) begin
            if (!we_q) rdata_q <= ext;
            state <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            state <= S_FAULT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;   // DONE and FAULT each last exactly one cycle
      endcase
    end
  end

  // The status outputs are decoded straight from the state flop.
  // Because of this, an asynchronous reset drops oBusReq immediately.
  assign bus.oBusReq   = (state == S_REQ);
  assign bus.oReady    = (state == S_DONE);
  assign bus.oFault    = (state == S_FAULT);
  assign bus.oBusy     = (state != S_IDLE);
  assign bus.oRData    = rdata_q;
  assign bus.oBusWE    = we_q;
  assign bus.oBusAddr  = addr_q;
  assign bus.oBusWData = wdata_q;
  assign bus.oBusBE    = be_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder.
// A driver issues the accesses and plays the memory, and it pushes one
// expectation per access from a byte-level reference model. A separate
// monitor checks the bus while oBusReq is high. It also pops and compares
// each expectation whenever oReady or oFault is presented.
module tb_mem_bus_responder;
  localparam int TO = 8;

  logic iCLK = 1'b0;
  logic iRST_N = 1'b0;
  always #5 iCLK = ~iCLK;

  mem_bus_responder_if bif();

  mem_bus_responder #(.TIMEOUT(TO)) dut (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .bus   (bif)
  );

  typedef struct {
    bit          fault;
    logic [31:0] rdata;
    int          req_cycles;
    bit          we;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [3:0]  be;
    bit          chk_be;
    bit          chk_wd;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_rdata = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // This is the reference model, written from the access rules. The access
  // size is a byte count. Alignment is checked as addr mod size. Extraction
  // is a shift followed by a mask. waits<0 means the memory never acks.
  function automatic exp_t model(input bit rd, input bit wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [2:0] st,
                                 input logic [2:0] lc, input logic [31:0] word,
                                 input int waits);
    exp_t e;
    int size;
    int off;
    logic [31:0] mask, v;
    off = int'(addr & 32'h3);
    e.fault = 0; e.rdata = model_rdata; e.req_cycles = 0; e.we = wr;
    e.baddr = addr & ~32'h3; e.bwdata = 0; e.be = 0; e.chk_be = 0; e.chk_wd = 0;
    if (rd && wr) begin e.fault = 1; return e; end
    if (wr) begin
      if (st > 2) begin e.fault = 1; return e; end
      size = 4 >> st;
    end else begin
      if (lc > 4) begin e.fault = 1; return e; end
      size = (lc == 0) ? 4 : (lc < 3) ? 2 : 1;
    end
    if (off % size != 0) begin e.fault = 1; return e; end
    if (waits < 0) begin e.fault = 1; e.req_cycles = TO; return e; end
    e.req_cycles = waits + 1;
    mask = (size == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * size)) - 32'h1;
    if (wr) begin
      e.be = 4'((1 << size) - 1) << off;
      v = wdata & mask;
      for (int i = 0; i < 4 / size; i++) e.bwdata = e.bwdata | (v << (8 * size * i));
      e.chk_be = 1; e.chk_wd = 1;
    end else begin
      v = (word >> (8 * off)) & mask;
      if ((lc == 1 || lc == 3) && v[8 * size - 1]) v = v | ~mask;
      e.rdata = v;
      model_rdata = v;
      e.be = 4'hF;
      e.chk_be = (lc == 0);
    end
    return e;
  endfunction

  // The driver enters and leaves this task on a falling edge, with the DUT idle.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] st, input logic [2:0] lc,
                        input int waits, input logic [31:0] word, input bit stray);
    exp_t e;
    int n;
    e = model(rd, wr, addr, wdata, st, lc, word, waits);
    q.push_back(e);
    bif.iMemRead = rd; bif.iMemWrite = wr; bif.iAddr = addr;
    bif.iWData = wdata; bif.iStore = st; bif.iLoadCase = lc;
    @(negedge iCLK);
    bif.iMemRead = 0; bif.iMemWrite = 0;
    if (e.req_cycles > 0 && waits >= 0) begin
      for (int i = 0; i < waits; i++) begin
        bif.iMemWrite = stray && (i == 0);
        @(negedge iCLK);
      end
      bif.iMemWrite = 0;
      bif.iBusAck = 1; bif.iBusRData = word;
      @(negedge iCLK);
      bif.iBusAck = 0; bif.iBusRData = $urandom;
    end
    n = 0;
    while (bif.oBusy && n < 400) begin @(negedge iCLK); n++; end
    if (bif.oBusy) begin
      failures++;
      $display("FAIL idle_wait actual=busy required=idle at %0t", $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {27'd0, bif.oBusReq, bif.oReady, bif.oFault, bif.oBusy, bif.oBusWE}, 32'd0);
    chk({tag, "_rdata"}, bif.oRData, 32'd0);
    chk({tag, "_addr"}, bif.oBusAddr, 32'd0);
    chk({tag, "_wdata"}, bif.oBusWData, 32'd0);
    chk({tag, "_be"}, {28'd0, bif.oBusBE}, 32'd0);
  endtask

  // The monitor samples 1 time unit after each rising edge.
  int reqc = 0;
  bit last_pulse = 0;
  always @(posedge iCLK) begin : mon
    exp_t e;
    #1;
    if (!iRST_N) begin
      reqc = 0; last_pulse = 0;
    end else begin
      if (last_pulse) chk("busy_after_pulse", {31'd0, bif.oBusy}, 32'd0);
      last_pulse = 0;
      if (bif.oBusReq) begin
        reqc++;
        if (q.size() == 0) begin
          failures++; $display("FAIL unexpected_req actual=1 required=0 at %0t", $time);
        end else begin
          e = q[0];
          chk("req_allowed", {31'd0, bif.oBusReq}, {31'd0, e.req_cycles > 0});
          chk("bus_addr", bif.oBusAddr, e.baddr);
          chk("bus_we", {31'd0, bif.oBusWE}, {31'd0, e.we});
          if (e.chk_be) chk("bus_be", {28'd0, bif.oBusBE}, {28'd0, e.be});
          if (e.chk_wd) chk("bus_wdata", bif.oBusWData, e.bwdata);
        end
      end
      if (bif.oReady || bif.oFault) begin
        if (q.size() == 0) begin
          failures++; $display("FAIL unexpected_pulse actual=1 required=0 at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("pulse_fault", {31'd0, bif.oFault}, {31'd0, e.fault});
          chk("pulse_ready", {31'd0, bif.oReady}, {31'd0, !e.fault});
          chk("rdata", bif.oRData, e.rdata);
          chk("req_cycles", reqc, e.req_cycles);
          chk("busy_at_pulse", {31'd0, bif.oBusy}, 32'd1);
        end
        reqc = 0;
        last_pulse = 1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, w;
    int r;
    bif.iMemRead = 0; bif.iMemWrite = 0; bif.iAddr = 0; bif.iWData = 0;
    bif.iStore = 0; bif.iLoadCase = 0; bif.iBusAck = 0; bif.iBusRData = 0;
    repeat (3) @(negedge iCLK);
    chk_all_zero("reset");
    iRST_N = 1;
    @(negedge iCLK);

    // Directed accesses
    access(1, 0, 32'h100, 0, 0, 0, 3, 32'hDEADBEEF, 0);
    access(0, 1, 32'h203, 32'h000000A5, 2, 0, 0, 0, 0);
    access(0, 1, 32'h302, 32'h1234BEEF, 1, 0, 1, 0, 0);
    access(1, 0, 32'h1003, 0, 0, 3, 1, 32'h80F0017F, 0);
    access(1, 0, 32'h1003, 0, 0, 4, 0, 32'h80F0017F, 0);
    access(1, 0, 32'h1002, 0, 0, 1, 2, 32'h80F0017F, 0);
    access(1, 0, 32'h1000, 0, 0, 2, 0, 32'h80F0017F, 0);
    // Illegal requests
    access(0, 1, 32'h102, 32'h55, 0, 0, 0, 0, 0);
    access(1, 0, 32'h101, 0, 0, 1, 0, 0, 0);
    access(1, 1, 32'h100, 0, 0, 0, 0, 0, 0);
    access(1, 0, 32'h100, 0, 0, 7, 0, 0, 0);
    // Timeout, then a normal access
    access(1, 0, 32'h400, 0, 0, 0, -1, 0, 0);
    access(1, 0, 32'h404, 0, 0, 0, 1, 32'hCAFEF00D, 0);
    // A stray strobe during REQ must be ignored
    access(1, 0, 32'h500, 0, 0, 0, 3, 32'h0BADF00D, 1);

    // Reset in the middle of REQ
    q.push_back(model(1, 0, 32'h600, 0, 0, 0, 32'h11111111, 5));
    bif.iMemRead = 1; bif.iAddr = 32'h600; bif.iLoadCase = 0;
    @(negedge iCLK);
    bif.iMemRead = 0;
    @(negedge iCLK);
    iRST_N = 0;
    void'(q.pop_front());
    model_rdata = 0;
    #1;
    chk_all_zero("midreq_reset");
    @(negedge iCLK);
    iRST_N = 1;
    @(negedge iCLK);
    access(1, 0, 32'h604, 0, 0, 3, 2, 32'h000000F0, 0);

    // Random accesses
    for (int k = 0; k < 60; k++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      w = $urandom;
      r = $urandom_range(0, 9);
      access(r < 6, r == 0 || r > 5, a, $urandom, 3'($urandom_range(0, 3)),
             3'($urandom_range(0, 5)), $urandom_range(0, 4), w, 0);
    end

    repeat (4) @(negedge iCLK);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
